// File: rtl/usb_data_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : usb_data_buffer_if                                           |
// | Description : Handshake/bus bundle for the shared USB data buffer.         |
// |               master modport = register block / USB stages (drivers)       |
// |               slave  modport = usb_data_buffer                             |
// |               Signals: clear, store_tx_data/tx_data, get_rx_data/rx_data,  |
// |               store_rx_packet_data/rx_packet_data,                         |
// |               get_tx_packet_data/tx_packet_data, buffer_occupancy,         |
// |               overflow, underflow.                                         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface usb_data_buffer_if #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             clear;
  logic             store_tx_data;
  logic [WIDTH-1:0] tx_data;
  logic             get_rx_data;
  logic [WIDTH-1:0] rx_data;
  logic             store_rx_packet_data;
  logic [WIDTH-1:0] rx_packet_data;
  logic             get_tx_packet_data;
  logic [WIDTH-1:0] tx_packet_data;
  logic [AW:0]      buffer_occupancy;
  logic             overflow;
  logic             underflow;

  modport master (
    output clear, store_tx_data, tx_data, get_rx_data,
           store_rx_packet_data, rx_packet_data, get_tx_packet_data,
    input  rx_data, tx_packet_data, buffer_occupancy, overflow, underflow
  );

  modport slave (
    input  clear, store_tx_data, tx_data, get_rx_data,
           store_rx_packet_data, rx_packet_data, get_tx_packet_data,
    output rx_data, tx_packet_data, buffer_occupancy, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/usb_data_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : usb_data_buffer                                              |
// | Description : Shared DEPTH x WIDTH circular buffer between the AHB-lite    |
// |               register block and the USB RX/TX packet stages.              |
// |               Ports: clk, rst (sync, active-high), bus (slave modport of   |
// |               usb_data_buffer_if: push/pop strobes and bytes, show-ahead   |
// |               head outputs, occupancy, sticky error flags).                |
// |               Optional feature macro USB_DATA_BUFFER_ERR_FLAGS_EN enables  |
// |               the sticky overflow/underflow flags; otherwise they read 0.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module usb_data_buffer #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8
) (
  input wire               clk,
  input wire               rst,
  usb_data_buffer_if.slave bus
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Storage has no reset; only the pointers define what is valid.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [AW:0]      occ_q, occ_d;

  logic             w_full, w_empty;
  logic             w_push, w_pop;
  logic             w_do_push, w_do_pop;
  logic             w_we;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_head;

  assign w_full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign w_empty = (wptr_q == rptr_q);

  assign w_push  = bus.store_rx_packet_data | bus.store_tx_data;
  assign w_pop   = bus.get_rx_data | bus.get_tx_packet_data;

  // USB RX wins a push collision; the AHB byte is dropped.
  assign w_wdata = bus.store_rx_packet_data ? bus.rx_packet_data : bus.tx_data;

  // A pop while full frees the slot the same cycle, so the push may proceed.
  assign w_do_pop  = w_pop & ~w_empty;
  assign w_do_push = w_push & (~w_full | w_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    w_we   = 1'b0;
    if (bus.clear) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (w_do_pop) begin
        rptr_d = rptr_q + PTR_ONE;
      end
      if (w_do_push) begin
        wptr_d = wptr_q + PTR_ONE;
        w_we   = 1'b1;
      end
    end
    occ_d = wptr_d - rptr_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we && !rst) begin
      mem[wptr_q[AW-1:0]] <= w_wdata;
    end
  end

  // Show-ahead head; reads as zero whenever nothing is held.
  assign w_head             = mem[rptr_q[AW-1:0]];
  assign bus.rx_data        = w_empty ? '0 : w_head;
  assign bus.tx_packet_data = w_empty ? '0 : w_head;
  assign bus.buffer_occupancy = occ_q;

`ifdef USB_DATA_BUFFER_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.clear) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      // A push collision always loses a byte, even when there is room.
      if ((bus.store_rx_packet_data & bus.store_tx_data) | (w_push & w_full & ~w_pop)) begin
        overflow_d = 1'b1;
      end
      if (w_pop & w_empty) begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_usb_data_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_usb_data_buffer                                           |
// | Description : Self-checking bench for usb_data_buffer: directed vector     |
// |               table, full/wrap sequences, and a randomized run against a   |
// |               queue-based reference model.                                 |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_usb_data_buffer;
  localparam int DEPTH = 64;
  localparam int WIDTH = 8;

`ifdef USB_DATA_BUFFER_ERR_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic clk;
  logic rst;

  usb_data_buffer_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  usb_data_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Reference model state
  logic [7:0] mq[$];
  bit         m_ovf;
  bit         m_udf;

  typedef struct {
    logic       r;
    logic       clr;
    logic       stx;
    logic [7:0] txd;
    logic       grx;
    logic       srx;
    logic [7:0] rxd;
    logic       gtx;
    logic [6:0] exp_occ;
    logic [7:0] exp_head;
    logic       exp_ovf;
    logic       exp_udf;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply inputs for one cycle, then return 1 time unit after the edge.
  task automatic drive(input logic r, input logic c, input logic stx, input logic [7:0] txd,
                       input logic grx, input logic srx, input logic [7:0] rxd, input logic gtx);
    rst                      = r;
    bus.clear                = c;
    bus.store_tx_data        = stx;
    bus.tx_data              = txd;
    bus.get_rx_data          = grx;
    bus.store_rx_packet_data = srx;
    bus.rx_packet_data       = rxd;
    bus.get_tx_packet_data   = gtx;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic check_state(input string tag, input int occ, input logic [7:0] head,
                             input logic ovf, input logic udf);
    check({tag, ".occ"},  32'(bus.buffer_occupancy), 32'(occ));
    check({tag, ".rxd"},  32'(bus.rx_data), 32'(head));
    check({tag, ".txpd"}, 32'(bus.tx_packet_data), 32'(head));
    check({tag, ".ovf"},  32'(bus.overflow), 32'(ovf & FLAGS));
    check({tag, ".udf"},  32'(bus.underflow), 32'(udf & FLAGS));
  endtask

  // Behavioural model: the buffer as a bounded byte queue.
  task automatic model_step(input logic r, input logic c, input logic stx, input logic [7:0] txd,
                            input logic grx, input logic srx, input logic [7:0] rxd, input logic gtx);
    bit push, pop, full, empty;
    if (r || c) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      return;
    end
    push  = stx | srx;
    pop   = grx | gtx;
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    if (stx && srx) m_ovf = 1'b1;
    if (push && full && !pop) m_ovf = 1'b1;
    if (pop && empty) m_udf = 1'b1;
    if (pop && !empty) void'(mq.pop_front());
    if (push && (!full || pop)) mq.push_back(srx ? rxd : txd);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst                      = 1'b1;
    bus.clear                = 1'b0;
    bus.store_tx_data        = 1'b0;
    bus.tx_data              = 8'h00;
    bus.get_rx_data          = 1'b0;
    bus.store_rx_packet_data = 1'b0;
    bus.rx_packet_data       = 8'h00;
    bus.get_tx_packet_data   = 1'b0;

    //           r    clr  stx  txd    grx  srx  rxd    gtx  occ  head   ovf  udf
    vecs[0]  = '{1'b1,1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0, 7'd0,8'h00, 1'b0,1'b0};
    vecs[1]  = '{1'b0,1'b0,1'b1,8'hA1,1'b0,1'b0,8'h00,1'b0, 7'd1,8'hA1, 1'b0,1'b0};
    vecs[2]  = '{1'b0,1'b0,1'b1,8'hB2,1'b0,1'b0,8'h00,1'b0, 7'd2,8'hA1, 1'b0,1'b0};
    vecs[3]  = '{1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b1, 7'd1,8'hB2, 1'b0,1'b0};
    vecs[4]  = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,8'h00,1'b1, 7'd0,8'h00, 1'b0,1'b0};
    vecs[5]  = '{1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b1, 7'd0,8'h00, 1'b0,1'b1};
    vecs[6]  = '{1'b0,1'b1,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0, 7'd0,8'h00, 1'b0,1'b0};
    vecs[7]  = '{1'b0,1'b0,1'b1,8'h22,1'b0,1'b1,8'h11,1'b0, 7'd1,8'h11, 1'b1,1'b0};
    vecs[8]  = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b1,8'h33,1'b0, 7'd1,8'h33, 1'b1,1'b0};
    vecs[9]  = '{1'b0,1'b1,1'b1,8'h44,1'b0,1'b0,8'h00,1'b0, 7'd0,8'h00, 1'b0,1'b0};
    vecs[10] = '{1'b0,1'b0,1'b1,8'h55,1'b0,1'b0,8'h00,1'b1, 7'd1,8'h55, 1'b0,1'b1};
    vecs[11] = '{1'b1,1'b0,1'b1,8'h66,1'b0,1'b0,8'h00,1'b0, 7'd0,8'h00, 1'b0,1'b0};

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].r, vecs[i].clr, vecs[i].stx, vecs[i].txd,
            vecs[i].grx, vecs[i].srx, vecs[i].rxd, vecs[i].gtx);
      check_state($sformatf("vec%0d", i), int'(vecs[i].exp_occ), vecs[i].exp_head,
                  vecs[i].exp_ovf, vecs[i].exp_udf);
    end

    // Fill to capacity, then one push too many.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b0, 1'b1, 8'(i), 1'b0, 1'b0, 8'h00, 1'b0);
    end
    check_state("fill64", 64, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0);
    check_state("push_full", 64, 8'h00, 1'b1, 1'b0);

    // Refill after reset, then push and pop together while full.
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b0, 1'b1, 8'(i), 1'b0, 1'b0, 8'h00, 1'b0);
    end
    check("full_pre.rxd", 32'(bus.rx_data), 32'h00);
    drive(1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0);
    check_state("full_pushpop", 64, 8'h01, 1'b0, 1'b0);

    // Drain everything: 0x01..0x3F then the 0x55 at the tail wrapped around.
    for (int i = 0; i < DEPTH; i++) begin
      logic [7:0] exp_b;
      exp_b = (i == DEPTH - 1) ? 8'h55 : 8'(i + 1);
      check($sformatf("drain%0d", i), 32'(bus.tx_packet_data), 32'(exp_b));
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    end
    check_state("drained", 0, 8'h00, 1'b0, 1'b0);

    // Randomized run against the queue model.
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    model_step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      logic r, c, stx, grx, srx, gtx;
      logic [7:0] txd, rxd;
      int pp;
      pp  = ((n / 500) % 2 == 0) ? 60 : 20;
      r   = ($urandom_range(0, 999) == 0);
      c   = ($urandom_range(0, 399) == 0);
      stx = ($urandom_range(0, 99) < pp);
      srx = ($urandom_range(0, 99) < pp / 3);
      grx = ($urandom_range(0, 99) < (80 - pp) / 2);
      gtx = ($urandom_range(0, 99) < (80 - pp) / 3);
      txd = 8'($urandom);
      rxd = 8'($urandom);
      model_step(r, c, stx, txd, grx, srx, rxd, gtx);
      drive(r, c, stx, txd, grx, srx, rxd, gtx);
      check_state($sformatf("rnd%0d", n), mq.size(),
                  (mq.size() != 0) ? mq[0] : 8'h00, m_ovf, m_udf);
    end

    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
